proc_run_checker: RTL and testbench
===================================

// Module: proc_run_checker
// PURPOSE
//  Synthesizable run/check harness for the pipelined processor. It counts the
//  run cycles after reset and waits out a drain window. It then sweeps the
//  register file through a spare read port and compares each register with an
//  expected-value table, counting mismatches. It also counts hazard stalls and
//  per-path bypass events. It sits beside skeleton in sim and on FPGA bring-up.
// PARAMETERS
//  DATA_W        32   register data width
//  NUM_REGS      32   registers swept, addresses 0..NUM_REGS-1
//  ADDR_W        5    register address width, clog2(NUM_REGS)
//  CYCLE_LIMIT   100  run cycles before checking starts
//  DRAIN_CYCLES  2    extra cycles for in-flight writebacks to retire
//  NUM_BYP       4    bypass paths monitored (fds, fxs, fdt, fxt)
//  CNT_W         16   width of every event/error counter (saturating)
//  STOP_ON_FIRST 0    1: end the sweep at the first mismatch
// PORTS
//  clock         in   1               system clock
//  reset         in   1               synchronous, active-high
//  stall_i       in   1               hazard stall this cycle
//  byp_i         in   NUM_BYP         bypass-path active flags
//  rd_addr_o     out  ADDR_W          register-file probe read address
//  rd_data_i     in   DATA_W          probe read data, combinational from rd_addr_o
//  exp_data_i    in   DATA_W          expected value for rd_addr_o (external ROM/table)
//  exp_chk_i     in   1               1: check this register; 0: skip it
//  phase_o       out  3               current FSM state encoding
//  done_o        out  1               check finished (sticky until reset)
//  pass_o        out  1               done_o && error_cnt_o==0
//  error_cnt_o   out  CNT_W           mismatch count
//  err_reg_o     out  ADDR_W          address of first mismatch
//  err_exp_o     out  DATA_W          expected value at first mismatch
//  err_got_o     out  DATA_W          read value at first mismatch
//  stall_cnt_o   out  CNT_W           stall cycles seen during RUN
//  byp_cnt_o     out  NUM_BYP*CNT_W   per-path bypass counts; path k at [k*CNT_W +: CNT_W]
// BEHAVIOUR
//  - Reset: state=RUN. All counters, err_* outputs, rd_addr_o, done_o and pass_o are 0.
//  - States: RUN -> DRAIN -> SWEEP -> DONE.
//  - RUN: cyc counts from 0 and increments every cycle. At cyc==CYCLE_LIMIT-1
//    the FSM goes to DRAIN. RUN therefore lasts exactly CYCLE_LIMIT cycles.
//    stall_cnt_o increments on each stall_i. byp_cnt_o[k] increments on each byp_i[k].
//  - DRAIN: lasts DRAIN_CYCLES cycles, then goes to SWEEP. Event counters are
//    frozen. DRAIN_CYCLES==0 goes straight from RUN to SWEEP.
//  - SWEEP: rd_addr_o steps 0,1,..,NUM_REGS-1, one address per cycle.
//    rd_data_i, exp_data_i and exp_chk_i are sampled in the same cycle as their address.
//    Compare result is registered, so error_cnt_o updates 1 cycle after the address.
//    A mismatch is exp_chk_i && rd_data_i!==exp_data_i (any X/Z counts as a mismatch).
//    Address 0 is always checked against 0, whatever exp_data_i and exp_chk_i say.
//  - First mismatch only: err_reg_o, err_exp_o and err_got_o are loaded; later mismatches leave them.
//  - Leaving SWEEP:
//    - STOP_ON_FIRST=0: go to DONE after the last address compare has registered.
//    - STOP_ON_FIRST=1: go to DONE the cycle after the first registered mismatch.
//  - DONE: done_o=1 and pass_o is valid. Both hold with rd_addr_o frozen until reset.
//  - Counters saturate at 2^CNT_W-1 and never wrap.
//  - Reset asserted in any state: everything restarts next cycle; there is no partial-result retention.
//  - Inputs stall_i/byp_i are ignored outside RUN.
// STRUCTURE
//  - Shared package proc_tb_pkg holds:
//    - state typedef and encodings: RUN=3'd1, DRAIN=3'd2, SWEEP=3'd3, DONE=3'd4;
//    - bypass index constants: BYP_FDS=0, BYP_FXS=1, BYP_FDT=2, BYP_FXT=3.
//  - One sub-module sat_counter #(W) (clock, reset, clr, inc, q).
//    It is instantiated for the stall count, the error count and NUM_BYP times for bypass counts.
//  - FSM, cycle/drain counters and the compare pipeline stay in this module.
// TESTING
//  1. CYCLE_LIMIT=10, DRAIN=2, regfile equal to table -> 1 + 32 registered compares (error_cnt 0,0,.. per cycle) and
//     done_o rises at cycle 10+2+32+1=45; pass_o=1, error_cnt_o=0.
//  2. Table matches except reg 7 (exp 0x0000_0005, got 0x0000_0006) and reg 20 ->
//     error_cnt_o=2, err_reg_o=7, err_exp_o=5, err_got_o=6, pass_o=0.
//  3. Same as 2 with STOP_ON_FIRST=1 -> done_o 1 cycle after the reg-7 compare registers, error_cnt_o=1.
//  4. stall_i high on 3 RUN cycles and in DRAIN, byp_i=4'b0101 for 4 RUN cycles ->
//     stall_cnt_o=3, byp_cnt path0=4, path2=4, paths 1 and 3=0.
//  5. CNT_W=2, stall_i held high for all 10 RUN cycles -> stall_cnt_o saturates at 3.
//  6. Reset pulsed mid-SWEEP after a mismatch -> all outputs return to 0 and the run restarts.
//     exp_chk_i=0 on reg 5 with a wrong value -> no error counted.

Source files
------------

// File: rtl/proc_tb_pkg.sv
// proc_tb_pkg: shared state encodings and bypass-path indices for the
// processor run/check harness.
`default_nettype none

package proc_tb_pkg;

    typedef enum logic [2:0] {
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_SWEEP = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int BYP_FDS = 0;
    localparam int BYP_FXS = 1;
    localparam int BYP_FDT = 2;
    localparam int BYP_FXT = 3;

endpackage

`default_nettype wire

// File: rtl/proc_run_checker_sat_counter.sv
// sat_counter: W-bit event counter that sticks at all-ones instead of wrapping.
`default_nettype none

module sat_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clock) begin
        if (reset || clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/proc_run_checker.sv
// proc_run_checker: counts run cycles, drains, then sweeps the register file
// against an expected-value table while tracking stall and bypass events.
`default_nettype none

module proc_run_checker
    import proc_tb_pkg::*;
#(
    parameter int DATA_W        = 32,
    parameter int NUM_REGS      = 32,
    parameter int ADDR_W        = 5,
    parameter int CYCLE_LIMIT   = 100,
    parameter int DRAIN_CYCLES  = 2,
    parameter int NUM_BYP       = 4,
    parameter int CNT_W         = 16,
    parameter int STOP_ON_FIRST = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     stall_i,
    input  logic [NUM_BYP-1:0]       byp_i,
    output logic [ADDR_W-1:0]        rd_addr_o,
    input  logic [DATA_W-1:0]        rd_data_i,
    input  logic [DATA_W-1:0]        exp_data_i,
    input  logic                     exp_chk_i,
    output logic [2:0]               phase_o,
    output logic                     done_o,
    output logic                     pass_o,
    output logic [CNT_W-1:0]         error_cnt_o,
    output logic [ADDR_W-1:0]        err_reg_o,
    output logic [DATA_W-1:0]        err_exp_o,
    output logic [DATA_W-1:0]        err_got_o,
    output logic [CNT_W-1:0]         stall_cnt_o,
    output logic [NUM_BYP*CNT_W-1:0] byp_cnt_o
);

    localparam int CYC_W = $clog2(CYCLE_LIMIT + 1);
    localparam int DRN_W = $clog2(DRAIN_CYCLES + 2);

    state_t              state, state_nxt;
    logic [CYC_W-1:0]    cyc;
    logic [DRN_W-1:0]    drn;
    logic                addr_done;
    logic                have_err;
    logic                in_run;
    logic                issue;
    logic                mismatch;
    logic                chk_eff;
    logic [DATA_W-1:0]   exp_eff;

    assign in_run = (state == ST_RUN);
    // After a stop-on-first hit the sweep stops issuing compares.
    assign issue  = (state == ST_SWEEP) && !addr_done &&
                    !((STOP_ON_FIRST != 0) && have_err);

    // Register 0 is hardwired, so it is always checked against zero.
    assign exp_eff  = (rd_addr_o == '0) ? '0 : exp_data_i;
    assign chk_eff  = (rd_addr_o == '0) || exp_chk_i;
    assign mismatch = chk_eff && (rd_data_i !== exp_eff);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (cyc == CYC_W'(CYCLE_LIMIT - 1)) begin
                    state_nxt = (DRAIN_CYCLES == 0) ? ST_SWEEP : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drn == DRN_W'(DRAIN_CYCLES - 1)) begin
                    state_nxt = ST_SWEEP;
                end
            end
            ST_SWEEP: begin
                if (addr_done || ((STOP_ON_FIRST != 0) && have_err)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE:  state_nxt = ST_DONE;
            default:  state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cyc       <= '0;
            drn       <= '0;
            rd_addr_o <= '0;
            addr_done <= 1'b0;
            have_err  <= 1'b0;
            err_reg_o <= '0;
            err_exp_o <= '0;
            err_got_o <= '0;
        end else begin
            if (in_run) begin
                cyc <= cyc + CYC_W'(1);
            end
            if (state == ST_DRAIN) begin
                drn <= drn + DRN_W'(1);
            end
            if (issue) begin
                if (rd_addr_o == ADDR_W'(NUM_REGS - 1)) begin
                    addr_done <= 1'b1;
                end else begin
                    rd_addr_o <= rd_addr_o + ADDR_W'(1);
                end
                if (mismatch && !have_err) begin
                    have_err  <= 1'b1;
                    err_reg_o <= rd_addr_o;
                    err_exp_o <= exp_eff;
                    err_got_o <= rd_data_i;
                end
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (1'b0),
        .inc   (in_run && stall_i),
        .q     (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_error_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (1'b0),
        .inc   (issue && mismatch),
        .q     (error_cnt_o)
    );

    for (genvar k = 0; k < NUM_BYP; k++) begin : g_byp
        sat_counter #(.W(CNT_W)) u_byp_cnt (
            .clock (clock),
            .reset (reset),
            .clr   (1'b0),
            .inc   (in_run && byp_i[k]),
            .q     (byp_cnt_o[k*CNT_W +: CNT_W])
        );
    end

    assign phase_o = state;
    assign done_o  = (state == ST_DONE);
    assign pass_o  = done_o && (error_cnt_o == '0);

endmodule

`default_nettype wire

// File: tb/tb_proc_run_checker.sv
// tb_proc_run_checker: scoreboard bench driving three checker configurations
// (free-running, stop-on-first, 2-bit counters) from shared register tables.
`default_nettype none

module tb_proc_run_checker;

    typedef struct {
        int          done_cyc;
        int          pass;
        int          errs;
        int          ereg;
        logic [31:0] eexp;
        logic [31:0] egot;
        int          stall;
        int          b0, b1, b2, b3;
        int          fe;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        stall_c;
    logic [3:0]  byp;

    logic [31:0] regs [32];
    logic [31:0] tbl  [32];
    logic        chk  [32];

    int total = 0;
    int bad   = 0;
    int tcyc  = 1000;
    logic rst_edge = 1'b0;
    logic armed    = 1'b0;

    exp_t qa[$], qb[$], qc[$];
    int   q_rst[$];

    // DUT A: free-running sweep, 16-bit counters
    logic [4:0]  addr_a, ereg_a;
    logic [2:0]  ph_a;
    logic        done_a, pass_a;
    logic [15:0] err_a, stl_a;
    logic [31:0] eexp_a, egot_a;
    logic [63:0] byp_a;

    // DUT B: stop on first mismatch
    logic [4:0]  addr_b, ereg_b;
    logic [2:0]  ph_b;
    logic        done_b, pass_b;
    logic [15:0] err_b, stl_b;
    logic [31:0] eexp_b, egot_b;
    logic [63:0] byp_b;

    // DUT C: 2-bit saturating counters
    logic [4:0]  addr_c, ereg_c;
    logic [2:0]  ph_c;
    logic        done_c, pass_c;
    logic [1:0]  err_c, stl_c;
    logic [31:0] eexp_c, egot_c;
    logic [7:0]  byp_c;

    proc_run_checker #(.CYCLE_LIMIT(10), .DRAIN_CYCLES(2), .CNT_W(16), .STOP_ON_FIRST(0)) dut_a (
        .clock(clock), .reset(reset), .stall_i(stall), .byp_i(byp),
        .rd_addr_o(addr_a), .rd_data_i(regs[addr_a]), .exp_data_i(tbl[addr_a]), .exp_chk_i(chk[addr_a]),
        .phase_o(ph_a), .done_o(done_a), .pass_o(pass_a), .error_cnt_o(err_a),
        .err_reg_o(ereg_a), .err_exp_o(eexp_a), .err_got_o(egot_a),
        .stall_cnt_o(stl_a), .byp_cnt_o(byp_a)
    );

    proc_run_checker #(.CYCLE_LIMIT(10), .DRAIN_CYCLES(2), .CNT_W(16), .STOP_ON_FIRST(1)) dut_b (
        .clock(clock), .reset(reset), .stall_i(stall), .byp_i(byp),
        .rd_addr_o(addr_b), .rd_data_i(regs[addr_b]), .exp_data_i(tbl[addr_b]), .exp_chk_i(chk[addr_b]),
        .phase_o(ph_b), .done_o(done_b), .pass_o(pass_b), .error_cnt_o(err_b),
        .err_reg_o(ereg_b), .err_exp_o(eexp_b), .err_got_o(egot_b),
        .stall_cnt_o(stl_b), .byp_cnt_o(byp_b)
    );

    proc_run_checker #(.CYCLE_LIMIT(10), .DRAIN_CYCLES(2), .CNT_W(2), .STOP_ON_FIRST(0)) dut_c (
        .clock(clock), .reset(reset), .stall_i(stall_c), .byp_i(byp),
        .rd_addr_o(addr_c), .rd_data_i(regs[addr_c]), .exp_data_i(tbl[addr_c]), .exp_chk_i(chk[addr_c]),
        .phase_o(ph_c), .done_o(done_c), .pass_o(pass_c), .error_cnt_o(err_c),
        .err_reg_o(ereg_c), .err_exp_o(eexp_c), .err_got_o(egot_c),
        .stall_cnt_o(stl_c), .byp_cnt_o(byp_c)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Cycle index relative to the last posedge that sampled reset high.
    always @(posedge clock) begin
        rst_edge <= reset;
        if (reset) tcyc <= 0;
        else       tcyc <= tcyc + 1;
    end

    task automatic chk_val(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic cmp_res(input string tag, input exp_t e, input int cyc, input int fe,
                           input logic pass, input logic [15:0] errs, input logic [4:0] ereg,
                           input logic [31:0] eexp, input logic [31:0] egot, input logic [15:0] stl,
                           input logic [15:0] b0, input logic [15:0] b1,
                           input logic [15:0] b2, input logic [15:0] b3);
        chk_val({tag, "_done_cycle"}, 64'(cyc), 64'(e.done_cyc));
        chk_val({tag, "_pass"},       64'(pass), 64'(e.pass));
        chk_val({tag, "_error_cnt"},  64'(errs), 64'(e.errs));
        chk_val({tag, "_err_reg"},    64'(ereg), 64'(e.ereg));
        chk_val({tag, "_err_exp"},    64'(eexp), 64'(e.eexp));
        chk_val({tag, "_err_got"},    64'(egot), 64'(e.egot));
        chk_val({tag, "_stall_cnt"},  64'(stl),  64'(e.stall));
        chk_val({tag, "_byp0"},       64'(b0),   64'(e.b0));
        chk_val({tag, "_byp1"},       64'(b1),   64'(e.b1));
        chk_val({tag, "_byp2"},       64'(b2),   64'(e.b2));
        chk_val({tag, "_byp3"},       64'(b3),   64'(e.b3));
        chk_val({tag, "_first_err_cycle"}, 64'(fe), 64'(e.fe));
    endtask

    // Monitor A: reset snapshots plus end-of-run results.
    initial begin
        int   fe = -1;
        logic pd = 1'b0;
        exp_t e;
        forever begin
            @(negedge clock);
            if (rst_edge) begin
                armed = 1'b1;
                fe = -1;
                pd = 1'b0;
                if (q_rst.size() > 0) begin
                    void'(q_rst.pop_front());
                    chk_val("rst_phase",     64'(ph_a),   64'(1));
                    chk_val("rst_done",      64'(done_a), 64'(0));
                    chk_val("rst_pass",      64'(pass_a), 64'(0));
                    chk_val("rst_error_cnt", 64'(err_a),  64'(0));
                    chk_val("rst_err_reg",   64'(ereg_a), 64'(0));
                    chk_val("rst_err_exp",   64'(eexp_a), 64'(0));
                    chk_val("rst_err_got",   64'(egot_a), 64'(0));
                    chk_val("rst_rd_addr",   64'(addr_a), 64'(0));
                    chk_val("rst_stall_cnt", 64'(stl_a),  64'(0));
                    chk_val("rst_byp_cnt",   byp_a,       64'(0));
                    chk_val("rst_b_done",    64'(done_b), 64'(0));
                    chk_val("rst_b_error",   64'(err_b),  64'(0));
                end
            end else if (armed) begin
                if (fe < 0 && err_a != 0) fe = tcyc;
                if (done_a && !pd) begin
                    if (qa.size() == 0) chk_val("a_unexpected_done", 64'(1), 64'(0));
                    else begin
                        e = qa.pop_front();
                        cmp_res("a", e, tcyc, fe, pass_a, err_a, ereg_a, eexp_a, egot_a, stl_a,
                                byp_a[15:0], byp_a[31:16], byp_a[47:32], byp_a[63:48]);
                    end
                end
                pd = done_a;
            end
        end
    end

    initial begin
        int   fe = -1;
        logic pd = 1'b0;
        exp_t e;
        forever begin
            @(negedge clock);
            if (rst_edge) begin
                fe = -1;
                pd = 1'b0;
            end else if (armed) begin
                if (fe < 0 && err_b != 0) fe = tcyc;
                if (done_b && !pd) begin
                    if (qb.size() == 0) chk_val("b_unexpected_done", 64'(1), 64'(0));
                    else begin
                        e = qb.pop_front();
                        cmp_res("b", e, tcyc, fe, pass_b, err_b, ereg_b, eexp_b, egot_b, stl_b,
                                byp_b[15:0], byp_b[31:16], byp_b[47:32], byp_b[63:48]);
                    end
                end
                pd = done_b;
            end
        end
    end

    initial begin
        int   fe = -1;
        logic pd = 1'b0;
        exp_t e;
        forever begin
            @(negedge clock);
            if (rst_edge) begin
                fe = -1;
                pd = 1'b0;
            end else if (armed) begin
                if (fe < 0 && err_c != 0) fe = tcyc;
                if (done_c && !pd) begin
                    if (qc.size() == 0) chk_val("c_unexpected_done", 64'(1), 64'(0));
                    else begin
                        e = qc.pop_front();
                        cmp_res("c", e, tcyc, fe, pass_c, 16'(err_c), ereg_c, eexp_c, egot_c, 16'(stl_c),
                                16'(byp_c[1:0]), 16'(byp_c[3:2]), 16'(byp_c[5:4]), 16'(byp_c[7:6]));
                    end
                end
                pd = done_c;
            end
        end
    end

    // Called #1 after posedge with tcyc==t; returns #1 after the posedge where tcyc==n.
    task automatic goto(input int n);
        repeat (n - tcyc) @(posedge clock);
        #1;
    endtask

    task automatic pulse_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_all_done(input string nm);
        int n = 0;
        while (!(done_a && done_b && done_c) && n < 200) begin
            @(posedge clock);
            n++;
        end
        if (n >= 200) chk_val({nm, "_timeout"}, 64'(n), 64'(0));
        repeat (2) @(posedge clock);
        #1;
    endtask

    initial begin
        exp_t ok_a, ok_c, bad2_a, bad2_b, bad2_c;
        reset   = 1'b1;
        stall   = 1'b0;
        stall_c = 1'b1;
        byp     = 4'b0000;
        for (int i = 0; i < 32; i++) begin
            tbl[i]  = 32'h0101_0101 * i + 32'h0000_00A5;
            regs[i] = tbl[i];
            chk[i]  = 1'b1;
        end
        // Register 0 must be compared against zero even though the table disagrees.
        tbl[0]  = 32'hDEAD_BEEF;
        regs[0] = 32'h0;

        // Run 1: clean register file, stalls and bypass pulses in RUN, stalls in DRAIN.
        ok_a = '{done_cyc:45, pass:1, errs:0, ereg:0, eexp:0, egot:0, stall:3,
                 b0:4, b1:0, b2:4, b3:0, fe:-1};
        ok_c = '{done_cyc:45, pass:1, errs:0, ereg:0, eexp:0, egot:0, stall:3,
                 b0:3, b1:0, b2:3, b3:0, fe:-1};
        qa.push_back(ok_a);
        qb.push_back(ok_a);
        qc.push_back(ok_c);
        q_rst.push_back(1);
        pulse_reset(2);
        goto(1);  stall = 1'b1;
        goto(4);  stall = 1'b0;
        goto(5);  byp   = 4'b0101;
        goto(9);  byp   = 4'b0000;
        goto(10); stall = 1'b1;
        goto(12); stall = 1'b0;
        wait_all_done("run1");

        // Run 2: mismatches at reg 7 and reg 20; reg 5 wrong but unchecked.
        tbl[7]   = 32'h0000_0005;
        regs[7]  = 32'h0000_0006;
        regs[20] = 32'h1234_5678;
        regs[5]  = 32'hFFFF_0000;
        chk[5]   = 1'b0;
        bad2_a = '{done_cyc:45, pass:0, errs:2, ereg:7, eexp:32'h5, egot:32'h6, stall:0,
                   b0:0, b1:0, b2:0, b3:0, fe:20};
        bad2_b = '{done_cyc:21, pass:0, errs:1, ereg:7, eexp:32'h5, egot:32'h6, stall:0,
                   b0:0, b1:0, b2:0, b3:0, fe:20};
        bad2_c = '{done_cyc:45, pass:0, errs:2, ereg:7, eexp:32'h5, egot:32'h6, stall:3,
                   b0:0, b1:0, b2:0, b3:0, fe:20};
        qa.push_back(bad2_a);
        qb.push_back(bad2_b);
        qc.push_back(bad2_c);
        pulse_reset(1);

        // Run 3: reset mid-SWEEP after the first mismatch. A and C never reached
        // DONE in run 2, so their queued entries are consumed by the restarted run.
        goto(25);
        qb.push_back(bad2_b);
        q_rst.push_back(1);
        pulse_reset(1);
        wait_all_done("run3");

        chk_val("a_pending", 64'(qa.size()), 64'(0));
        chk_val("b_pending", 64'(qb.size()), 64'(0));
        chk_val("c_pending", 64'(qc.size()), 64'(0));
        chk_val("rst_pending", 64'(q_rst.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
